// File: rtl/code_word_packer_pkg.sv
// Shared constants and state type for the code word packer.
package code_word_packer_pkg;

  localparam int MAX_CODE_LEN = 34;   // widest code in bits
  localparam int LEN_W        = 6;    // width of the length field
  localparam int CNT_W        = 5;    // width of the per-line word counter
  localparam int WORD_W       = 64;   // packed output word width
  localparam int ACC_W        = 128;  // accumulator width (max fill 63+34=97)
  localparam int FILL_W       = 6;    // stored fill is always < WORD_W

  typedef enum logic [1:0] {
    RUN,
    FLUSH_REM,
    FLUSH_PAD
  } pack_state_t;

endpackage

// File: rtl/code_word_packer_mask_shift.sv
// Combinational code conditioning: clamps the length, clears bits above the
// length and shifts the surviving bits up to the current fill position.
module code_mask_shift
  import code_word_packer_pkg::*;
(
  input  logic [MAX_CODE_LEN-1:0] i_code,
  input  logic [LEN_W-1:0]        i_len,
  input  logic [FILL_W-1:0]       i_fill,
  output logic [LEN_W-1:0]        o_len,
  output logic [ACC_W-1:0]        o_field
);

  localparam logic [MAX_CODE_LEN:0] ONE_EXT = 1;

  logic [LEN_W-1:0]        w_len;
  logic [MAX_CODE_LEN:0]   w_mask_ext;
  logic [MAX_CODE_LEN-1:0] w_masked;

  // Saturate the length, build a mask one bit wider than the code so that a
  // full-width code does not overflow the shift, then place the code at fill.
  always_comb begin
    w_len      = (i_len > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN) : i_len;
    w_mask_ext = (ONE_EXT << w_len) - ONE_EXT;
    w_masked   = i_code & w_mask_ext[MAX_CODE_LEN-1:0];
    o_len      = w_len;
    o_field    = {{(ACC_W-MAX_CODE_LEN){1'b0}}, w_masked} << i_fill;
  end

endmodule

// File: rtl/code_word_packer.sv
// Packs variable-length codes LSB-first into 64-bit words; on flush emits the
// zero-padded remainder and pads the line to an even number of words.
module code_word_packer
  import code_word_packer_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [MAX_CODE_LEN-1:0] i_code,
  input  logic [LEN_W-1:0]        i_len,
  input  logic                    i_flush,
  output logic                    o_ready,
  output logic [WORD_W-1:0]       o_word,
  output logic                    o_word_valid,
  output logic                    o_done,
  output logic [CNT_W-1:0]        o_line_words
);

  pack_state_t         r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [FILL_W-1:0]   r_fill;
  logic [CNT_W-1:0]    r_count;
  logic [WORD_W-1:0]   r_word;
  logic                r_word_valid;
  logic                r_done;

  pack_state_t         w_state_next;
  logic [ACC_W-1:0]    w_acc_next;
  logic [FILL_W-1:0]   w_fill_next;
  logic [CNT_W-1:0]    w_count_next;
  logic [WORD_W-1:0]   w_word_next;
  logic                w_word_valid_next;
  logic                w_done_next;

  logic                w_run;
  logic                w_valid_acc;
  logic                w_flush_acc;
  logic [LEN_W-1:0]    w_len;
  logic [ACC_W-1:0]    w_field;
  logic [ACC_W-1:0]    w_acc_n;
  logic [FILL_W:0]     w_fill_n;
  logic                w_fill_full;
  logic [CNT_W-1:0]    w_count_base;

  code_mask_shift u_mask_shift (
    .i_code  (i_code),
    .i_len   (i_len),
    .i_fill  (r_fill),
    .o_len   (w_len),
    .o_field (w_field)
  );

  // Append the accepted code; the counter restarts from 0 right after o_done.
  always_comb begin
    w_run        = (r_state == RUN);
    w_valid_acc  = i_valid && w_run;
    w_flush_acc  = i_flush && w_run;
    w_acc_n      = w_valid_acc ? (r_acc | w_field) : r_acc;
    w_fill_n     = {1'b0, r_fill} + (w_valid_acc ? {1'b0, w_len} : '0);
    w_fill_full  = w_fill_n[FILL_W];
    w_count_base = r_done ? '0 : r_count;
  end

  // Next-state and emit decisions for the run/flush sequence.
  always_comb begin
    w_state_next      = r_state;
    w_acc_next        = r_acc;
    w_fill_next       = r_fill;
    w_count_next      = w_count_base;
    w_word_next       = r_word;
    w_word_valid_next = 1'b0;
    w_done_next       = 1'b0;
    case (r_state)
      RUN: begin
        w_acc_next  = w_acc_n;
        w_fill_next = w_fill_n[FILL_W-1:0];
        if (w_fill_full) begin
          // Subtracting 64 from a value below 128 just drops the top bit.
          w_word_next       = w_acc_n[WORD_W-1:0];
          w_word_valid_next = 1'b1;
          w_acc_next        = w_acc_n >> WORD_W;
          w_count_next      = w_count_base + 1'b1;
        end
        if (w_flush_acc) begin
          if (w_fill_full && (w_fill_n[FILL_W-1:0] != '0)) begin
            w_state_next = FLUSH_REM;
          end else begin
            if (!w_fill_full && (w_fill_n != '0)) begin
              // Bits above fill are already zero, so this is the padded word.
              w_word_next       = w_acc_n[WORD_W-1:0];
              w_word_valid_next = 1'b1;
              w_acc_next        = '0;
              w_fill_next       = '0;
              w_count_next      = w_count_base + 1'b1;
            end
            if (w_count_next[0]) begin
              w_state_next = FLUSH_PAD;
            end else begin
              w_done_next = 1'b1;
            end
          end
        end
      end
      FLUSH_REM: begin
        w_word_next       = r_acc[WORD_W-1:0];
        w_word_valid_next = 1'b1;
        w_acc_next        = '0;
        w_fill_next       = '0;
        w_count_next      = w_count_base + 1'b1;
        if (w_count_next[0]) begin
          w_state_next = FLUSH_PAD;
        end else begin
          w_done_next  = 1'b1;
          w_state_next = RUN;
        end
      end
      FLUSH_PAD: begin
        w_word_next       = '0;
        w_word_valid_next = 1'b1;
        w_count_next      = w_count_base + 1'b1;
        w_done_next       = 1'b1;
        w_state_next      = RUN;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc        <= '0;
      r_fill       <= '0;
      r_count      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_acc        <= w_acc_next;
      r_fill       <= w_fill_next;
      r_count      <= w_count_next;
      r_word       <= w_word_next;
      r_word_valid <= w_word_valid_next;
      r_done       <= w_done_next;
    end
  end

  assign o_ready      = (r_state == RUN);
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_done       = r_done;
  assign o_line_words = r_count;

endmodule

// File: tb/tb_code_word_packer.sv
// Directed bench for code_word_packer with hand-computed expectations.
module tb_code_word_packer;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic [33:0] i_code;
  logic [5:0]  i_len;
  logic        i_flush;
  logic        o_ready;
  logic [63:0] o_word;
  logic        o_word_valid;
  logic        o_done;
  logic [4:0]  o_line_words;

  int n_cmp;
  int n_err;

  localparam logic [33:0] ONES34 = '1;

  code_word_packer dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_code       (i_code),
    .i_len        (i_len),
    .i_flush      (i_flush),
    .o_ready      (o_ready),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .o_done       (o_done),
    .o_line_words (o_line_words)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One line per emitted word or line completion.
  always @(negedge i_clk) begin
    if (o_word_valid || o_done)
      $display("[%0t] word_valid=%0b word=%h done=%0b line_words=%0d",
               $time, o_word_valid, o_word, o_done, o_line_words);
  end

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [33:0] code, input logic [5:0] len,
                     input logic fl);
    i_valid = v; i_code = code; i_len = len; i_flush = fl;
    @(posedge i_clk); #1;
    i_valid = 0; i_code = '0; i_len = '0; i_flush = 0;
  endtask

  task automatic test_reset();
    i_reset = 1; i_valid = 0; i_code = '0; i_len = '0; i_flush = 0;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    n_cmp++; if (o_word_valid !== 1'b0 || o_done !== 1'b0) begin n_err++; $display("FAIL reset_pulses got=%b%b exp=00", o_word_valid, o_done); end
    n_cmp++; if (o_word !== 64'h0 || o_line_words !== 5'd0) begin n_err++; $display("FAIL reset_word got=%h/%0d exp=0/0", o_word, o_line_words); end
    repeat (2) @(posedge i_clk);
    #1 i_reset = 0;
  endtask

  // Exact fill followed by a flush that only needs a pad word.
  task automatic test_exact_fill();
    cyc(1, ONES34, 6'd34, 0);
    n_cmp++; if (o_word_valid !== 1'b0) begin n_err++; $display("FAIL exact_nofill got=%b exp=0", o_word_valid); end
    cyc(1, 34'h1, 6'd30, 0);
    n_cmp++; if (o_word_valid !== 1'b1 || o_word !== 64'h0000_0007_FFFF_FFFF) begin n_err++; $display("FAIL exact_word got=%b/%h exp=1/00000007ffffffff", o_word_valid, o_word); end
    n_cmp++; if (o_line_words !== 5'd1) begin n_err++; $display("FAIL exact_count got=%0d exp=1", o_line_words); end
    cyc(0, '0, '0, 1);
    n_cmp++; if (o_ready !== 1'b0 || o_word_valid !== 1'b0) begin n_err++; $display("FAIL padonly_wait got=%b/%b exp=0/0", o_ready, o_word_valid); end
    cyc(0, '0, '0, 0);
    n_cmp++; if (o_word_valid !== 1'b1 || o_word !== 64'h0 || o_done !== 1'b1) begin n_err++; $display("FAIL padonly_word got=%b/%h/%b exp=1/0/1", o_word_valid, o_word, o_done); end
    n_cmp++; if (o_line_words !== 5'd2 || o_ready !== 1'b1) begin n_err++; $display("FAIL padonly_count got=%0d/%b exp=2/1", o_line_words, o_ready); end
    cyc(0, '0, '0, 0);
    n_cmp++; if (o_done !== 1'b0 || o_line_words !== 5'd0) begin n_err++; $display("FAIL padonly_clear got=%b/%0d exp=0/0", o_done, o_line_words); end
  endtask

  task automatic test_flush_with_code();
    cyc(1, 34'hA5, 6'd8, 1);
    n_cmp++; if (o_word_valid !== 1'b1 || o_word !== 64'hA5 || o_line_words !== 5'd1) begin n_err++; $display("FAIL fcode_word got=%b/%h/%0d exp=1/a5/1", o_word_valid, o_word, o_line_words); end
    n_cmp++; if (o_ready !== 1'b0 || o_done !== 1'b0) begin n_err++; $display("FAIL fcode_busy got=%b/%b exp=0/0", o_ready, o_done); end
    cyc(0, '0, '0, 0);
    n_cmp++; if (o_word_valid !== 1'b1 || o_word !== 64'h0 || o_done !== 1'b1 || o_line_words !== 5'd2) begin n_err++; $display("FAIL fcode_pad got=%b/%h/%b/%0d exp=1/0/1/2", o_word_valid, o_word, o_done, o_line_words); end
    cyc(0, '0, '0, 0);
    n_cmp++; if (o_ready !== 1'b1 || o_word_valid !== 1'b0) begin n_err++; $display("FAIL fcode_ready got=%b/%b exp=1/0", o_ready, o_word_valid); end
  endtask

  // One full word, then a straddling code, then a flush of the 4-bit tail.
  task automatic test_straddle();
    cyc(1, ONES34, 6'd34, 0);
    cyc(1, 34'h1, 6'd30, 0);
    cyc(1, ONES34, 6'd34, 0);
    cyc(1, ONES34, 6'd26, 0);
    n_cmp++; if (o_word_valid !== 1'b0) begin n_err++; $display("FAIL straddle_fill60 got=%b exp=0", o_word_valid); end
    cyc(1, 34'hFF, 6'd8, 0);
    n_cmp++; if (o_word_valid !== 1'b1 || o_word !== 64'hFFFF_FFFF_FFFF_FFFF || o_line_words !== 5'd2) begin n_err++; $display("FAIL straddle_word got=%b/%h/%0d exp=1/ffffffffffffffff/2", o_word_valid, o_word, o_line_words); end
    cyc(0, '0, '0, 1);
    n_cmp++; if (o_word_valid !== 1'b1 || o_word !== 64'hF || o_done !== 1'b0 || o_line_words !== 5'd3) begin n_err++; $display("FAIL straddle_tail got=%b/%h/%b/%0d exp=1/f/0/3", o_word_valid, o_word, o_done, o_line_words); end
    cyc(0, '0, '0, 0);
    n_cmp++; if (o_word_valid !== 1'b1 || o_word !== 64'h0 || o_done !== 1'b1 || o_line_words !== 5'd4) begin n_err++; $display("FAIL straddle_pad got=%b/%h/%b/%0d exp=1/0/1/4", o_word_valid, o_word, o_done, o_line_words); end
    cyc(0, '0, '0, 0);
  endtask

  // Length 4 keeps only 0xF, length 0 adds nothing, length 40 acts as 34.
  task automatic test_mask_clamp();
    cyc(1, ONES34, 6'd4, 0);
    cyc(1, ONES34, 6'd0, 0);
    cyc(1, ONES34, 6'd40, 0);
    cyc(0, '0, '0, 1);
    n_cmp++; if (o_word_valid !== 1'b1 || o_word !== 64'h0000_003F_FFFF_FFFF || o_line_words !== 5'd1) begin n_err++; $display("FAIL mask_word got=%b/%h/%0d exp=1/0000003fffffffff/1", o_word_valid, o_word, o_line_words); end
    cyc(0, '0, '0, 0);
    n_cmp++; if (o_word !== 64'h0 || o_done !== 1'b1 || o_line_words !== 5'd2) begin n_err++; $display("FAIL mask_pad got=%h/%b/%0d exp=0/1/2", o_word, o_done, o_line_words); end
    cyc(0, '0, '0, 0);
  endtask

  task automatic test_reset_mid_flush();
    cyc(1, ONES34, 6'd34, 0);
    cyc(1, ONES34, 6'd26, 0);
    cyc(1, 34'hFF, 6'd8, 1);
    n_cmp++; if (o_ready !== 1'b0 || o_word !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL midflush_enter got=%b/%h exp=0/ffffffffffffffff", o_ready, o_word); end
    #2 i_reset = 1;
    #1;
    n_cmp++; if (o_ready !== 1'b1 || o_word_valid !== 1'b0 || o_done !== 1'b0) begin n_err++; $display("FAIL midflush_reset got=%b/%b/%b exp=1/0/0", o_ready, o_word_valid, o_done); end
    n_cmp++; if (o_word !== 64'h0 || o_line_words !== 5'd0) begin n_err++; $display("FAIL midflush_regs got=%h/%0d exp=0/0", o_word, o_line_words); end
    @(posedge i_clk); #1 i_reset = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(0, '0, '0, 0);
      n_cmp++; if (o_done !== 1'b0 || o_word_valid !== 1'b0) begin n_err++; $display("FAIL midflush_quiet[%0d] got=%b/%b exp=0/0", k, o_done, o_word_valid); end
    end
  endtask

  task automatic test_empty_flush();
    cyc(0, '0, '0, 1);
    n_cmp++; if (o_done !== 1'b1 || o_word_valid !== 1'b0 || o_line_words !== 5'd0) begin n_err++; $display("FAIL empty_done got=%b/%b/%0d exp=1/0/0", o_done, o_word_valid, o_line_words); end
    cyc(0, '0, '0, 0);
    n_cmp++; if (o_done !== 1'b0 || o_ready !== 1'b1) begin n_err++; $display("FAIL empty_after got=%b/%b exp=0/1", o_done, o_ready); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_exact_fill();
    test_flush_with_code();
    test_straddle();
    test_mask_clamp();
    test_reset_mid_flush();
    test_empty_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
